ikbd_acia_rx: RTL and testbench

Host-side serial receiver for the keyboard controller's SCI transmit line. It plays the role of the ST's 6850 ACIA receive half. It deserialises 8N1 frames sent by the HD63701 (P24/TxD) and queues the received bytes in a small first-word-fall-through FIFO. Bench and system logic read the FIFO and error flags. It sits between the controller's PO2 TxD bit and the host bus model.

---
 rtl/ikbd_acia_rx.sv | 183 ++++++++++++++++++
 tb/tb_ikbd_acia_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ikbd_acia_rx.sv
// ikbd_acia_rx -- host-side 8N1 serial receiver (6850 ACIA receive half)
// for the keyboard controller's SCI TxD line, with a small
// first-word-fall-through byte FIFO and sticky error flags.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   res        asynchronous active-high reset
//   rxd        serial input, idle high, asynchronous to clk
//   rx_rd      pop request; ignored while the FIFO is empty
//   rx_data    FIFO head byte (meaningful while rx_valid=1)
//   rx_valid   FIFO not empty
//   rx_count   entries held, 0..DEPTH
//   err_clr    clears frame_err and overrun (a coincident set wins)
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a byte arrived while the FIFO was full
//   busy       receiver FSM is not idle
module ikbd_acia_rx #(
  parameter int unsigned CLKS_PER_BIT = 256,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     rxd,
  input  logic                     rx_rd,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  output logic [$clog2(DEPTH):0]   rx_count,
  input  logic                     err_clr,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          r_state, w_state_n;
  logic            r_sync1, r_rxs;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [2:0]      r_bit, w_bit_n;
  logic [7:0]      r_shift, w_shift_n;
  logic            w_push, w_ferr_set;

  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [AW:0]     r_count;
  logic            w_pop, w_full, w_push_ok, w_ovr_set;

  // Two-flop synchroniser; idle level is high.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt + CW'(1);
    w_bit_n    = r_bit;
    w_shift_n  = r_shift;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Counter is held at zero so START always begins from a clean count.
        w_cnt_n = '0;
        if (!r_rxs) w_state_n = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_n = '0;
          if (r_rxs) begin
            w_state_n = S_IDLE;
          end else begin
            w_bit_n   = '0;
            w_state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_n          = '0;
          w_shift_n[r_bit] = r_rxs;
          w_bit_n          = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_n = '0;
          if (r_rxs) begin
            w_push    = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_ferr_set = 1'b1;
            w_state_n  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_cnt_n = '0;
        if (r_rxs) w_state_n = S_IDLE;
      end
      default: begin
        w_cnt_n   = '0;
        w_state_n = S_IDLE;
      end
    endcase
  end

  // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
  assign w_pop     = rx_rd && (r_count != '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr] <= r_shift;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      unique case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (w_ferr_set)   frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (w_ovr_set)    overrun   <= 1'b1;
      else if (err_clr) overrun   <= 1'b0;
    end
  end

  assign rx_data  = r_mem[r_rd];
  assign rx_valid = (r_count != '0);
  assign rx_count = r_count;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_ikbd_acia_rx.sv
// Testbench for ikbd_acia_rx: a fast-bit instance (16 clk/bit, 4 entries)
// covers framing, FIFO and error behaviour; a default-parameter instance
// confirms nominal bit-period timing.
module tb_ikbd_acia_rx;

  localparam int C     = 16;
  localparam int CD    = 256;
  localparam int DEPTH = 4;
  // Edge, counted from the edge the start bit is launched after, at which the
  // stop bit is sampled: 2 sync flops + 1 idle detect + half bit + 9 bits.
  localparam int SE    = 3 + C / 2 + 9 * C;

  logic clk = 1'b0;
  logic res;
  logic rxd_a, rd_a, clr_a;
  logic [7:0] data_a;
  logic valid_a, ferr_a, ovr_a, busy_a;
  logic [2:0] cnt_a;
  logic rxd_b, rd_b, clr_b;
  logic [7:0] data_b;
  logic valid_b, ferr_b, ovr_b, busy_b;
  logic [2:0] cnt_b;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic m_ovr;

  always #5 clk = ~clk;

  ikbd_acia_rx #(.CLKS_PER_BIT(C), .DEPTH(DEPTH)) dut (
    .clk(clk), .res(res), .rxd(rxd_a), .rx_rd(rd_a), .rx_data(data_a),
    .rx_valid(valid_a), .rx_count(cnt_a), .err_clr(clr_a),
    .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a));

  ikbd_acia_rx dut_d (
    .clk(clk), .res(res), .rxd(rxd_b), .rx_rd(rd_b), .rx_data(data_b),
    .rx_valid(valid_b), .rx_count(cnt_b), .err_clr(clr_b),
    .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // FIFO behaviour of the receiver seen as a bounded queue.
  function automatic void model_push(input logic [7:0] d);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else m_ovr = 1'b1;
  endfunction

  task automatic send_a(input logic [7:0] d, input logic stop, input int rd_edge,
                        output logic v_pre, output logic v_post);
    v_pre = 1'bx;
    v_post = 1'bx;
    for (int cyc = 0; cyc < 10 * C; cyc++) begin
      int idx;
      idx = cyc / C;
      rxd_a = (idx == 0) ? 1'b0 : (idx == 9) ? stop : d[idx-1];
      rd_a  = (cyc == rd_edge - 1);
      tick;
      if (cyc + 1 == SE - 1) v_pre = valid_a;
      if (cyc + 1 == SE) v_post = valid_a;
    end
    rxd_a = 1'b1;
    rd_a  = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    for (int cyc = 0; cyc < 10 * CD; cyc++) begin
      int idx;
      idx = cyc / CD;
      rxd_b = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : d[idx-1];
      tick;
    end
    rxd_b = 1'b1;
  endtask

  task automatic pulse_rd_a;
    rd_a = 1'b1;
    tick;
    rd_a = 1'b0;
  endtask

  task automatic pulse_clr_a;
    clr_a = 1'b1;
    tick;
    clr_a = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
    checks++; if (cnt_a !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
    checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data got=%02h exp=00", data_a); end
    checks++; if ({ferr_a, ovr_a, busy_a} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {ferr_a, ovr_a, busy_a}); end
    checks++; if ({valid_b, busy_b} !== 2'b00) begin failures++; $display("FAIL reset_b got=%b exp=00", {valid_b, busy_b}); end
  endtask

  task automatic test_single;
    logic vp, vq;
    send_a(8'hA5, 1'b1, -1, vp, vq);
    model_push(8'hA5);
    checks++; if ({vp, vq} !== 2'b01) begin failures++; $display("FAIL single_valid_timing got=%b exp=01", {vp, vq}); end
    checks++; if (data_a !== 8'hA5) begin failures++; $display("FAIL single_data got=%02h exp=a5", data_a); end
    checks++; if (cnt_a !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", cnt_a); end
    checks++; if (ferr_a !== 1'b0) begin failures++; $display("FAIL single_ferr got=%b exp=0", ferr_a); end
    pulse_rd_a;
    void'(exp_q.pop_front());
    checks++; if ({valid_a, cnt_a} !== 4'b0_000) begin failures++; $display("FAIL single_pop got=%b/%0d exp=0/0", valid_a, cnt_a); end
  endtask

  task automatic test_overrun;
    logic vp, vq;
    for (int i = 1; i <= 5; i++) begin
      send_a(8'(i), 1'b1, -1, vp, vq);
      model_push(8'(i));
    end
    checks++; if (cnt_a !== 3'(exp_q.size())) begin failures++; $display("FAIL ovr_count got=%0d exp=%0d", cnt_a, exp_q.size()); end
    checks++; if (ovr_a !== m_ovr) begin failures++; $display("FAIL ovr_flag got=%b exp=%b", ovr_a, m_ovr); end
    while (exp_q.size() > 0) begin
      checks++; if (valid_a !== 1'b1 || data_a !== exp_q[0]) begin failures++; $display("FAIL ovr_drain got=%b/%02h exp=1/%02h", valid_a, data_a, exp_q[0]); end
      pulse_rd_a;
      void'(exp_q.pop_front());
    end
    pulse_clr_a;
    m_ovr = 1'b0;
    checks++; if (ovr_a !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", ovr_a); end
  endtask

  task automatic test_full_push_pop;
    logic vp, vq;
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      send_a(d, 1'b1, -1, vp, vq);
      model_push(d);
    end
    send_a(8'h55, 1'b1, SE, vp, vq);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    checks++; if (ovr_a !== 1'b0) begin failures++; $display("FAIL pp_overrun got=%b exp=0", ovr_a); end
    checks++; if (cnt_a !== 3'd4) begin failures++; $display("FAIL pp_count got=%0d exp=4", cnt_a); end
    while (exp_q.size() > 0) begin
      checks++; if (valid_a !== 1'b1 || data_a !== exp_q[0]) begin failures++; $display("FAIL pp_drain got=%b/%02h exp=1/%02h", valid_a, data_a, exp_q[0]); end
      pulse_rd_a;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_frame_err;
    logic vp, vq;
    send_a(8'h3C, 1'b0, -1, vp, vq);
    checks++; if (ferr_a !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b exp=1", ferr_a); end
    checks++; if (cnt_a !== 3'd0) begin failures++; $display("FAIL ferr_count got=%0d exp=0", cnt_a); end
    pulse_clr_a;
    checks++; if (ferr_a !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", ferr_a); end
    rxd_a = 1'b0;
    repeat (20 * C) tick;
    checks++; if ({ferr_a, busy_a} !== 2'b11) begin failures++; $display("FAIL break_first got=%b exp=11", {ferr_a, busy_a}); end
    pulse_clr_a;
    repeat (20 * C) tick;
    checks++; if ({ferr_a, cnt_a} !== 4'b0_000) begin failures++; $display("FAIL break_once got=%b/%0d exp=0/0", ferr_a, cnt_a); end
    rxd_a = 1'b1;
    repeat (2 * C) tick;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL break_exit got=%b exp=0", busy_a); end
    send_a(8'h81, 1'b1, -1, vp, vq);
    checks++; if ({valid_a, data_a, ferr_a} !== {1'b1, 8'h81, 1'b0}) begin failures++; $display("FAIL after_break got=%b/%02h/%b exp=1/81/0", valid_a, data_a, ferr_a); end
    pulse_rd_a;
  endtask

  task automatic test_glitch_reset;
    logic vp, vq;
    logic [7:0] d;
    rxd_a = 1'b0;
    repeat (4) tick;
    rxd_a = 1'b1;
    repeat (C) tick;
    checks++; if ({busy_a, valid_a, ferr_a} !== 3'b000) begin failures++; $display("FAIL glitch got=%b exp=000", {busy_a, valid_a, ferr_a}); end
    d = 8'($urandom);
    send_a(d, 1'b1, -1, vp, vq);
    checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", valid_a); end
    rxd_a = 1'b0;
    repeat (C) tick;
    for (int i = 0; i < 3 * C; i++) begin
      rxd_a = 1'($urandom);
      tick;
    end
    res = 1'b1;
    rxd_a = 1'b1;
    #1;
    checks++; if ({valid_a, cnt_a, data_a, busy_a, ferr_a, ovr_a} !== 15'd0) begin failures++; $display("FAIL mid_reset got=%b/%0d/%02h/%b%b%b exp=0/0/00/000", valid_a, cnt_a, data_a, busy_a, ferr_a, ovr_a); end
    tick;
    tick;
    res = 1'b0;
    exp_q.delete();
    repeat (2 * C) tick;
    checks++; if ({valid_a, busy_a} !== 2'b00) begin failures++; $display("FAIL post_reset got=%b exp=00", {valid_a, busy_a}); end
    send_a(8'h7E, 1'b1, -1, vp, vq);
    checks++; if ({valid_a, cnt_a, data_a} !== {1'b1, 3'd1, 8'h7E}) begin failures++; $display("FAIL reset_next got=%b/%0d/%02h exp=1/1/7e", valid_a, cnt_a, data_a); end
    pulse_rd_a;
  endtask

  task automatic test_random;
    logic vp, vq;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      send_a(d, 1'b1, -1, vp, vq);
      model_push(d);
      checks++; if (cnt_a !== 3'(exp_q.size()) || ovr_a !== m_ovr) begin failures++; $display("FAIL rnd_state got=%0d/%b exp=%0d/%b", cnt_a, ovr_a, exp_q.size(), m_ovr); end
      if ($urandom_range(0, 1) == 1) begin
        checks++; if (data_a !== exp_q[0]) begin failures++; $display("FAIL rnd_pop got=%02h exp=%02h", data_a, exp_q[0]); end
        pulse_rd_a;
        void'(exp_q.pop_front());
      end
    end
    while (exp_q.size() > 0) begin
      checks++; if (valid_a !== 1'b1 || data_a !== exp_q[0]) begin failures++; $display("FAIL rnd_drain got=%b/%02h exp=1/%02h", valid_a, data_a, exp_q[0]); end
      pulse_rd_a;
      void'(exp_q.pop_front());
    end
    pulse_rd_a;
    checks++; if (cnt_a !== 3'd0) begin failures++; $display("FAIL rd_empty got=%0d exp=0", cnt_a); end
    pulse_clr_a;
    m_ovr = 1'b0;
  endtask

  task automatic test_default_baud;
    logic [7:0] bq[$];
    bq = '{8'hF8, 8'h00, 8'hFF};
    foreach (bq[i]) send_b(bq[i]);
    checks++; if ({cnt_b, ferr_b, ovr_b} !== {3'd3, 2'b00}) begin failures++; $display("FAIL dflt_state got=%0d/%b%b exp=3/00", cnt_b, ferr_b, ovr_b); end
    while (bq.size() > 0) begin
      checks++; if (valid_b !== 1'b1 || data_b !== bq[0]) begin failures++; $display("FAIL dflt_data got=%b/%02h exp=1/%02h", valid_b, data_b, bq[0]); end
      rd_b = 1'b1;
      tick;
      rd_b = 1'b0;
      void'(bq.pop_front());
    end
  endtask

  initial begin
    res = 1'b1;
    rxd_a = 1'b1; rd_a = 1'b0; clr_a = 1'b0;
    rxd_b = 1'b1; rd_b = 1'b0; clr_b = 1'b0;
    m_ovr = 1'b0;
    repeat (3) tick;
    res = 1'b0;
    tick;
    test_reset;
    test_single;
    test_overrun;
    test_full_push_pop;
    test_frame_err;
    test_glitch_reset;
    test_random;
    test_default_baud;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
